// File: rtl/wb_host_master.sv
// Wishbone B4 classic single-transfer initiator: cmd stream in, one bus
// cycle per command, read data + status out on a rsp stream, with watchdog.
// Ports: wb_clk_i/wb_rst_ni; cmd_* (valid/ready command); rsp_* (valid/ready
// response, status 00 ok / 01 err / 10 timeout); busy; wbm_* Wishbone master.
module wb_host_master #(
  parameter int ADR_W          = 32,
  parameter int DAT_W          = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic [ADR_W-1:0]   cmd_adr,
  input  logic [DAT_W-1:0]   cmd_dat,
  input  logic [DAT_W/8-1:0] cmd_sel,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DAT_W-1:0]   rsp_dat,
  output logic [1:0]         rsp_status,
  output logic               busy,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [ADR_W-1:0]   wbm_adr_o,
  output logic [DAT_W-1:0]   wbm_dat_o,
  output logic [DAT_W/8-1:0] wbm_sel_o,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i,
  input  logic [DAT_W-1:0]   wbm_dat_i
);

  localparam int SEL_W = DAT_W / 8;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam int TO_LAST = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TO_W-1:0] TO_LAST_C = TO_W'(TO_LAST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q;
  logic [TO_W-1:0]   cnt_q;
  logic              rdy_q;
  logic              cyc_q;
  logic              we_q;
  logic [ADR_W-1:0]  adr_q;
  logic [DAT_W-1:0]  dat_q;
  logic [SEL_W-1:0]  sel_q;
  logic              rvld_q;
  logic [DAT_W-1:0]  rdat_q;
  logic [1:0]        rsts_q;

  // rdy_q mirrors (state == IDLE) but is held low during reset so that
  // every output reads 0 while wb_rst_ni is asserted.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rvld_q  <= 1'b0;
      rdat_q  <= '0;
      rsts_q  <= 2'b00;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_valid && rdy_q) begin
            we_q    <= cmd_we;
            adr_q   <= cmd_adr;
            dat_q   <= cmd_dat;
            sel_q   <= cmd_sel;
            cyc_q   <= 1'b1;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            state_q <= BUS;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        BUS: begin
          if (wbm_err_i) begin
            rsts_q  <= 2'b01;
            rdat_q  <= '0;
            cyc_q   <= 1'b0;
            rvld_q  <= 1'b1;
            state_q <= RESP;
          end else if (wbm_ack_i) begin
            rsts_q  <= 2'b00;
            rdat_q  <= we_q ? '0 : wbm_dat_i;
            cyc_q   <= 1'b0;
            rvld_q  <= 1'b1;
            state_q <= RESP;
          end else if (TO_EN && cnt_q == TO_LAST_C) begin
            rsts_q  <= 2'b10;
            rdat_q  <= '0;
            cyc_q   <= 1'b0;
            rvld_q  <= 1'b1;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rvld_q  <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          cyc_q   <= 1'b0;
          rvld_q  <= 1'b0;
          rdy_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = rdy_q;
  assign busy       = (state_q != IDLE);
  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = cyc_q;
  assign wbm_we_o   = we_q;
  assign wbm_adr_o  = adr_q;
  assign wbm_dat_o  = dat_q;
  assign wbm_sel_o  = sel_q;
  assign rsp_valid  = rvld_q;
  assign rsp_dat    = rdat_q;
  assign rsp_status = rsts_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Randomized scoreboard bench for wb_host_master: transfer plans feed a
// slave model; expected responses are queued and checked by a monitor.
module tb_wb_host_master;

  localparam int T = 4;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic        busy;
  logic        cyc, stb, we;
  logic [31:0] adr, dato;
  logic [3:0]  sel;
  logic        ack, err;
  logic [31:0] dati;

  wb_host_master #(
    .ADR_W(32), .DAT_W(32), .TIMEOUT_CYCLES(T), .TO_W(8)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_adr(cmd_adr),
    .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dat(rsp_dat), .rsp_status(rsp_status),
    .busy(busy),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
    .wbm_adr_o(adr), .wbm_dat_o(dato), .wbm_sel_o(sel),
    .wbm_ack_i(ack), .wbm_err_i(err), .wbm_dat_i(dati)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          k;      // stb cycle of the slave reply, 0 = never
    int          typ;    // 0 ack, 1 err, 2 ack+err
    logic [31:0] rdata;
    bit          abort;
  } plan_t;

  typedef struct {
    logic [31:0] dat;
    logic [1:0]  sts;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  // Reference: reply within the watchdog window wins (err over ack),
  // otherwise the watchdog fires after T strobe cycles.
  function automatic exp_t model(plan_t p);
    exp_t e;
    if (p.k != 0 && p.k <= T) begin
      e.sts = (p.typ != 0) ? 2'b01 : 2'b00;
    end else begin
      e.sts = 2'b10;
    end
    e.dat = (e.sts == 2'b00 && !p.we) ? p.rdata : 32'h0;
    return e;
  endfunction

  function automatic int stb_len(plan_t p);
    return (p.k != 0 && p.k <= T) ? p.k : T;
  endfunction

  // Slave model
  plan_t sp;
  bit    sact = 0;
  int    sn   = 0;
  always @(negedge clk) begin
    if (stb) begin
      if (!sact) begin
        if (plan_q.size() == 0) begin
          errors++;
          $display("FAIL unplanned_bus_cycle @%0t", $time);
          sp = '{1'b0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 1'b1};
        end else begin
          sp = plan_q.pop_front();
          chk("bus_we", {63'h0, we}, {63'h0, sp.we});
          chk("bus_adr", {32'h0, adr}, {32'h0, sp.adr});
          chk("bus_sel", {60'h0, sel}, {60'h0, sp.sel});
          if (sp.we) chk("bus_dat", {32'h0, dato}, {32'h0, sp.dat});
          chk("bus_cyc", {63'h0, cyc}, 64'h1);
          chk("busy_bus", {63'h0, busy}, 64'h1);
        end
        sact = 1;
        sn   = 0;
      end
      sn++;
      if (sn == sp.k) begin
        ack  = (sp.typ != 1);
        err  = (sp.typ != 0);
        dati = sp.rdata;
      end else begin
        ack  = 1'b0;
        err  = 1'b0;
        dati = $urandom;
      end
    end else begin
      // spurious replies outside a bus cycle must be ignored
      ack  = ($urandom_range(0, 7) == 0);
      err  = ($urandom_range(0, 7) == 0);
      dati = $urandom;
      if (sact) begin
        sact = 0;
        if (!sp.abort)
          chk("stb_len", 64'(sn), 64'(stb_len(sp)));
      end
    end
  end

  // Response monitor
  exp_t me;
  bit   have = 0;
  bit   hs   = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      have = 0;
      hs   = 0;
      rsp_ready = 1'b0;
    end else begin
      if (hs) begin
        have = 0;
        chk("post_hs_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        chk("post_hs_cmd_ready", {63'h0, cmd_ready}, 64'h1);
      end
      if (rsp_valid) begin
        if (!have) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp dat=%0h sts=%0d", rsp_dat, rsp_status);
            me = '{32'h0, 2'b11};
          end else begin
            me = exp_q.pop_front();
          end
          have = 1;
        end
        chk("rsp_dat", {32'h0, rsp_dat}, {32'h0, me.dat});
        chk("rsp_status", {62'h0, rsp_status}, {62'h0, me.sts});
        chk("rsp_cmd_ready", {63'h0, cmd_ready}, 64'h0);
      end
      rsp_ready = ($urandom_range(0, 2) == 0);
      hs = rsp_valid && rsp_ready;
    end
  end

  task automatic issue(plan_t p);
    bit ok = 0;
    plan_q.push_back(p);
    if (!p.abort) exp_q.push_back(model(p));
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we  = p.we;
    cmd_adr = p.adr;
    cmd_dat = p.dat;
    cmd_sel = p.sel;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      errors++;
      $display("FAIL cmd_accept_timeout adr=%0h", p.adr);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cmd_dat = $urandom;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !rsp_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d", exp_q.size());
    end
  endtask

  task automatic chk_idle_outputs(string tag, logic rdy);
    logic [63:0] v;
    v = {cyc, stb, we, rsp_valid, busy, rsp_status, 57'h0};
    chk({tag, "_ctrl"}, v, 64'h0);
    chk({tag, "_bus"}, {adr, dato}, 64'h0);
    chk({tag, "_rsp"}, {28'h0, sel, rsp_dat}, 64'h0);
    chk({tag, "_cmd_ready"}, {63'h0, cmd_ready}, {63'h0, rdy});
  endtask

  initial begin
    plan_t p;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_we = 1'b0;
    cmd_adr = '0;
    cmd_dat = '0;
    cmd_sel = '0;
    ack = 1'b0;
    err = 1'b0;
    dati = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("in_reset", 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_idle_outputs("post_reset", 1'b1);

    // zero-wait write
    issue('{1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 1, 0, 32'h0, 1'b0});
    // wait-state read, acked in the last watchdog cycle
    issue('{1'b0, 32'h3000_0000, 32'h0, 4'hF, 4, 0, 32'hDEAD_BEEF, 1'b0});
    // ack and err together
    issue('{1'b0, 32'h3000_0008, 32'h0, 4'hF, 1, 2, 32'h1111_1111, 1'b0});
    // silent slave
    issue('{1'b0, 32'h3000_000C, 32'h0, 4'h3, 0, 0, 32'h5555_AAAA, 1'b0});
    // reply one cycle too late
    issue('{1'b1, 32'h3000_0010, 32'h1234_5678, 4'h1, 5, 0, 32'h0, 1'b0});

    for (int n = 0; n < 60; n++) begin
      p.we    = $urandom_range(0, 1);
      p.adr   = $urandom;
      p.dat   = $urandom;
      p.sel   = 4'($urandom);
      p.k     = $urandom_range(0, 6);
      p.typ   = $urandom_range(0, 2);
      p.rdata = $urandom;
      p.abort = 1'b0;
      issue(p);
    end
    drain();

    // mid-transfer reset
    issue('{1'b0, 32'h3000_0020, 32'h0, 4'hF, 0, 0, 32'h0, 1'b1});
    @(negedge clk);
    chk("pre_abort_stb", {63'h0, stb}, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cyc", {63'h0, cyc}, 64'h0);
    chk("abort_stb", {63'h0, stb}, 64'h0);
    chk("abort_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    chk("abort_busy", {63'h0, busy}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue('{1'b0, 32'h3000_0024, 32'h0, 4'hF, 2, 0, 32'hCAFE_F00D, 1'b0});
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
